// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder
//  Purpose  : Pipelined RV32I instruction encoder. Packs decoded fields
//             (format, opcode, registers, funct bits, immediate) into a
//             32-bit instruction word. Each word gets a sequential byte
//             address. Immediates that cannot be represented are flagged.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W     width of the generated byte address
//    BASE_ADDR  address of the first word after reset or clear
//  Ports
//    clk, rst_n        clock (rising edge), asynchronous active-low reset
//    clear_i           synchronous restart of address, count and halt state
//    in_valid_i        field bundle valid
//    in_ready_o        encoder can accept a bundle
//    fmt_i             0=R 1=I 2=S 3=SB 4=U 5=UJ (6,7 illegal)
//    opcode_i          opcode field
//    rd_i, rs1_i, rs2_i register fields
//    funct3_i          funct3 field
//    funct7_i          funct7 field
//    imm_i             signed byte-offset immediate (U: full upper value)
//    out_valid_o       encoded word valid
//    out_ready_i       downstream accepts
//    out_instr_o       encoded word (NOP on error)
//    out_addr_o        byte address of out_instr_o
//    out_err_o         0=ok 1=range 2=misaligned 3=illegal fmt
//    count_o           good words emitted since reset/clear (saturating)
//  Build option
//    ENCODER_RANGE_CHECK_EN  when defined, enables the immediate range and
//                            alignment checks. When undefined, out-of-range
//                            immediate bits are truncated and only an
//                            illegal format is reported.
// ============================================================================
module instr_encoder #(
    parameter int unsigned          ADDR_W    = 10,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        fmt_i,
    input  logic [6:0]        opcode_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [31:0]       imm_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_instr_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic [1:0]        out_err_o,
    output logic [15:0]       count_o
);

    localparam logic [2:0]  FMT_R  = 3'd0;
    localparam logic [2:0]  FMT_I  = 3'd1;
    localparam logic [2:0]  FMT_S  = 3'd2;
    localparam logic [2:0]  FMT_SB = 3'd3;
    localparam logic [2:0]  FMT_U  = 3'd4;
    localparam logic [2:0]  FMT_UJ = 3'd5;

    localparam logic [1:0]  ERR_OK    = 2'd0;
    localparam logic [1:0]  ERR_RANGE = 2'd1;
    localparam logic [1:0]  ERR_ALIGN = 2'd2;
    localparam logic [1:0]  ERR_FMT   = 2'd3;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [31:0]         out_instr_q, out_instr_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic [1:0]          out_err_q, out_err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         count_q, count_d;

    logic [31:0]         w_word;
    logic [1:0]          w_err;
    logic                w_accept;

`ifdef ENCODER_RANGE_CHECK_EN
    // An immediate fits a field when every bit above the field's sign bit
    // matches it, i.e. the upper slice is all zeros or all ones.
    logic w_fits_i;
    logic w_fits_sb;
    logic w_fits_uj;
    assign w_fits_i  = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign w_fits_sb = (&imm_i[31:12]) | ~(|imm_i[31:12]);
    assign w_fits_uj = (&imm_i[31:20]) | ~(|imm_i[31:20]);
`endif

    // ------------------------------------------------------------------
    // Field packing and error classification.
    // Priority is illegal fmt > misaligned > range; each format only
    // raises the errors that apply to it, so a single if-chain per
    // format realises the priority.
    // ------------------------------------------------------------------
    always_comb begin
        w_word = '0;
        w_err  = ERR_OK;
        case (fmt_i)
            FMT_R: begin
                w_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            end
            FMT_I: begin
                w_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
`ifdef ENCODER_RANGE_CHECK_EN
                if (!w_fits_i) w_err = ERR_RANGE;
`endif
            end
            FMT_S: begin
                w_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
`ifdef ENCODER_RANGE_CHECK_EN
                if (!w_fits_i) w_err = ERR_RANGE;
`endif
            end
            FMT_SB: begin
                w_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                          imm_i[4:1], imm_i[11], opcode_i};
`ifdef ENCODER_RANGE_CHECK_EN
                if (imm_i[0])        w_err = ERR_ALIGN;
                else if (!w_fits_sb) w_err = ERR_RANGE;
`endif
            end
            FMT_U: begin
                w_word = {imm_i[31:12], rd_i, opcode_i};
`ifdef ENCODER_RANGE_CHECK_EN
                if (imm_i[11:0] != 12'd0) w_err = ERR_RANGE;
`endif
            end
            FMT_UJ: begin
                w_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                          rd_i, opcode_i};
`ifdef ENCODER_RANGE_CHECK_EN
                if (imm_i[0])        w_err = ERR_ALIGN;
                else if (!w_fits_uj) w_err = ERR_RANGE;
`endif
            end
            default: begin
                w_err = ERR_FMT;
            end
        endcase
        if (w_err != ERR_OK) begin
            w_word = NOP_WORD;
        end
    end

    // rst_n is included so that in_ready stays low while reset is held
    // and rises combinationally the moment it is released.
    assign in_ready_o = rst_n && !clear_i && (state_q == ST_RUN) &&
                        (!out_valid_q || out_ready_i);
    assign w_accept   = in_valid_i && in_ready_o;

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = ST_RUN;
        end else if (w_accept && (w_err != ERR_OK)) begin
            state_d = ST_HALT;
        end
    end

    // ------------------------------------------------------------------
    // Datapath next state: output register, address and good-word count
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        out_err_d   = out_err_q;
        addr_d      = addr_q;
        count_d     = count_q;
        if (clear_i) begin
            // Any pending word is dropped on restart.
            out_valid_d = 1'b0;
            out_addr_d  = BASE_ADDR;
            addr_d      = BASE_ADDR;
            count_d     = '0;
        end else if (w_accept) begin
            out_valid_d = 1'b1;
            out_instr_d = w_word;
            out_addr_d  = addr_q;
            out_err_d   = w_err;
            if (w_err == ERR_OK) begin
                addr_d = addr_q + ADDR_STEP;
                if (count_q != 16'hFFFF) begin
                    count_d = count_q + 16'd1;
                end
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= BASE_ADDR;
            out_err_q   <= ERR_OK;
            addr_q      <= BASE_ADDR;
            count_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            out_err_q   <= out_err_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_instr_o = out_instr_q;
    assign out_addr_o  = out_addr_q;
    assign out_err_o   = out_err_q;
    assign count_o     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_encoder
//  Purpose  : Directed self-checking bench for instr_encoder. Expected
//             values are hand-computed; those that depend on the
//             ENCODER_RANGE_CHECK_EN build option are selected with it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        clear_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [2:0]  fmt_i;
    logic [6:0]  opcode_i;
    logic [4:0]  rd_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] imm_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_instr_o;
    logic [9:0]  out_addr_o;
    logic [1:0]  out_err_o;
    logic [15:0] count_o;

    int n_checks;
    int n_fail;

    instr_encoder #(
        .ADDR_W    (10),
        .BASE_ADDR (10'h000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clear_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .fmt_i       (fmt_i),
        .opcode_i    (opcode_i),
        .rd_i        (rd_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .funct3_i    (funct3_i),
        .funct7_i    (funct7_i),
        .imm_i       (imm_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_instr_o (out_instr_o),
        .out_addr_o  (out_addr_o),
        .out_err_o   (out_err_o),
        .count_o     (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are driven and outputs
    // sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bundle(input logic [2:0] f, input logic [6:0] op,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [31:0] imm);
        fmt_i    = f;
        opcode_i = op;
        rd_i     = rd;
        rs1_i    = rs1;
        rs2_i    = rs2;
        funct3_i = f3;
        funct7_i = 7'd0;
        imm_i    = imm;
    endtask

    task automatic do_clear();
        in_valid_i = 1'b0;
        clear_i    = 1'b1;
        tick();
        clear_i    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        set_bundle(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
        tick(); tick();
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b exp 0", out_valid_o); end
        n_checks++; if (out_instr_o !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %08h exp 00000000", out_instr_o); end
        n_checks++; if (out_addr_o !== 10'h000) begin n_fail++; $display("FAIL reset_addr got %03h exp 000", out_addr_o); end
        n_checks++; if (out_err_o !== 2'd0) begin n_fail++; $display("FAIL reset_err got %0d exp 0", out_err_o); end
        n_checks++; if (count_o !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count_o); end
        n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %0b exp 0", in_ready_o); end
        #2 rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %0b exp 1", in_ready_o); end
        @(negedge clk); #1;  // realign to posedge+1
        @(posedge clk); #1;
    endtask

    task automatic test_addi();
        // addi x1,x0,5 -> 0x00500093
        set_bundle(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
        in_valid_i = 1'b1;
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL addi_pre_valid got %0b exp 0", out_valid_o); end
        tick();
        in_valid_i = 1'b0;
        n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %0b exp 1", out_valid_o); end
        n_checks++; if (out_instr_o !== 32'h00500093) begin n_fail++; $display("FAIL addi_instr got %08h exp 00500093", out_instr_o); end
        n_checks++; if (out_addr_o !== 10'h000) begin n_fail++; $display("FAIL addi_addr got %03h exp 000", out_addr_o); end
        n_checks++; if (out_err_o !== 2'd0) begin n_fail++; $display("FAIL addi_err got %0d exp 0", out_err_o); end
        tick();
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL addi_drain got %0b exp 0", out_valid_o); end
        n_checks++; if (count_o !== 16'd1) begin n_fail++; $display("FAIL addi_count got %0d exp 1", count_o); end
        do_clear();
        n_checks++; if (count_o !== 16'd0) begin n_fail++; $display("FAIL clear_count got %0d exp 0", count_o); end
    endtask

    task automatic test_back_to_back();
        // sw x1,8(x2) then jal x1,-4
        out_ready_i = 1'b1;
        set_bundle(3'd2, 7'h23, 5'd0, 5'd2, 5'd1, 3'd2, 32'd8);
        in_valid_i = 1'b1;
        tick();
        n_checks++; if (out_instr_o !== 32'h00112423) begin n_fail++; $display("FAIL sw_instr got %08h exp 00112423", out_instr_o); end
        n_checks++; if (out_addr_o !== 10'h000) begin n_fail++; $display("FAIL sw_addr got %03h exp 000", out_addr_o); end
        set_bundle(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC);
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready got %0b exp 1", in_ready_o); end
        tick();
        in_valid_i = 1'b0;
        n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL jal_valid got %0b exp 1", out_valid_o); end
        n_checks++; if (out_instr_o !== 32'hFFDFF0EF) begin n_fail++; $display("FAIL jal_instr got %08h exp FFDFF0EF", out_instr_o); end
        n_checks++; if (out_addr_o !== 10'h004) begin n_fail++; $display("FAIL jal_addr got %03h exp 004", out_addr_o); end
        n_checks++; if (count_o !== 16'd2) begin n_fail++; $display("FAIL b2b_count got %0d exp 2", count_o); end
        tick();
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %0b exp 0", out_valid_o); end
    endtask

    task automatic test_misaligned();
        // SB with imm=3 at address 0x008 (after the two words above)
        set_bundle(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3);
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        n_checks++; if (out_addr_o !== 10'h008) begin n_fail++; $display("FAIL sb_addr got %03h exp 008", out_addr_o); end
`ifdef ENCODER_RANGE_CHECK_EN
        n_checks++; if (out_err_o !== 2'd2) begin n_fail++; $display("FAIL sb_err got %0d exp 2", out_err_o); end
        n_checks++; if (out_instr_o !== 32'h00000013) begin n_fail++; $display("FAIL sb_instr got %08h exp 00000013", out_instr_o); end
        n_checks++; if (count_o !== 16'd2) begin n_fail++; $display("FAIL sb_count got %0d exp 2", count_o); end
        n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL sb_halt_ready got %0b exp 0", in_ready_o); end
        tick();
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL sb_drain got %0b exp 0", out_valid_o); end
        in_valid_i = 1'b1;
        #1;
        n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL halt_hold_ready got %0b exp 0", in_ready_o); end
        tick();
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL halt_no_accept got %0b exp 0", out_valid_o); end
        // clear with simultaneous in_valid: not accepted
        clear_i = 1'b1;
        #1;
        n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL clear_in_ready got %0b exp 0", in_ready_o); end
        tick();
        clear_i = 1'b0;
        in_valid_i = 1'b0;
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL clear_valid got %0b exp 0", out_valid_o); end
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL clear_run got %0b exp 1", in_ready_o); end
        n_checks++; if (out_addr_o !== 10'h000) begin n_fail++; $display("FAIL clear_addr got %03h exp 000", out_addr_o); end
`else
        n_checks++; if (out_err_o !== 2'd0) begin n_fail++; $display("FAIL sb_err got %0d exp 0", out_err_o); end
        n_checks++; if (out_instr_o !== 32'h00000163) begin n_fail++; $display("FAIL sb_instr got %08h exp 00000163", out_instr_o); end
        n_checks++; if (count_o !== 16'd3) begin n_fail++; $display("FAIL sb_count got %0d exp 3", count_o); end
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL sb_run_ready got %0b exp 1", in_ready_o); end
        tick();
        do_clear();
        n_checks++; if (out_addr_o !== 10'h000) begin n_fail++; $display("FAIL clear_addr got %03h exp 000", out_addr_o); end
`endif
        n_checks++; if (count_o !== 16'd0) begin n_fail++; $display("FAIL clear_count2 got %0d exp 0", count_o); end
    endtask

    task automatic test_range_and_fmt();
        set_bundle(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'd2048);
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
`ifdef ENCODER_RANGE_CHECK_EN
        n_checks++; if (out_err_o !== 2'd1) begin n_fail++; $display("FAIL range_err got %0d exp 1", out_err_o); end
        n_checks++; if (out_instr_o !== 32'h00000013) begin n_fail++; $display("FAIL range_instr got %08h exp 00000013", out_instr_o); end
        n_checks++; if (count_o !== 16'd0) begin n_fail++; $display("FAIL range_count got %0d exp 0", count_o); end
`else
        n_checks++; if (out_err_o !== 2'd0) begin n_fail++; $display("FAIL range_err got %0d exp 0", out_err_o); end
        n_checks++; if (out_instr_o !== 32'h80000013) begin n_fail++; $display("FAIL range_instr got %08h exp 80000013", out_instr_o); end
        n_checks++; if (count_o !== 16'd1) begin n_fail++; $display("FAIL range_count got %0d exp 1", count_o); end
`endif
        tick();
        do_clear();
        set_bundle(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0);
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        n_checks++; if (out_err_o !== 2'd3) begin n_fail++; $display("FAIL fmt_err got %0d exp 3", out_err_o); end
        n_checks++; if (out_instr_o !== 32'h00000013) begin n_fail++; $display("FAIL fmt_instr got %08h exp 00000013", out_instr_o); end
        n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL fmt_halt got %0b exp 0", in_ready_o); end
        tick();
        do_clear();
    endtask

    task automatic test_backpressure();
        out_ready_i = 1'b0;
        set_bundle(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
        in_valid_i = 1'b1;
        tick();
        // second bundle: addi x2,x0,1 -> 0x00100113
        set_bundle(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'd1);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %0b exp 0", i, in_ready_o); end
            n_checks++; if (out_instr_o !== 32'h00500093 || out_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_hold[%0d] got %08h/%0b exp 00500093/1", i, out_instr_o, out_valid_o); end
            tick();
        end
        out_ready_i = 1'b1;
        #1;
        n_checks++; if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %0b exp 1", in_ready_o); end
        tick();
        in_valid_i = 1'b0;
        n_checks++; if (out_instr_o !== 32'h00100113) begin n_fail++; $display("FAIL bp_second_instr got %08h exp 00100113", out_instr_o); end
        n_checks++; if (out_addr_o !== 10'h004) begin n_fail++; $display("FAIL bp_second_addr got %03h exp 004", out_addr_o); end
        tick();
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got %0b exp 0", out_valid_o); end
        n_checks++; if (count_o !== 16'd2) begin n_fail++; $display("FAIL bp_count got %0d exp 2", count_o); end
    endtask

    task automatic test_async_reset();
        set_bundle(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        n_checks++; if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL ar_pre_valid got %0b exp 1", out_valid_o); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL ar_async_valid got %0b exp 0", out_valid_o); end
        tick();
        rst_n = 1'b1;
        out_ready_i = 1'b1;
        tick();
        n_checks++; if (out_addr_o !== 10'h000) begin n_fail++; $display("FAIL ar_addr got %03h exp 000", out_addr_o); end
        n_checks++; if (count_o !== 16'd0) begin n_fail++; $display("FAIL ar_count got %0d exp 0", count_o); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_addi();
        test_back_to_back();
        test_misaligned();
        test_range_and_fmt();
        test_backpressure();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
